// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled 8N1 UART receiver with host handshake,
// framing-error pulse and sticky overrun flag.
// Optional even-parity support is compiled in with `define UART_RX_PARITY_EN,
// which adds a PARITY state and the parity_err output.
module uart_rx_os #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 s_data,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sd;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   stop_smp;
  logic                   stop_good;
  logic                   consume;
  logic [DATA_BITS-1:0]   rx_d;
  logic                   valid_d, overrun_d, frame_err_d;

`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
`else
  localparam logic        par_bad_q = 1'b0;
`endif

  // Input synchroniser; preset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], s_data};
  end

  assign sd      = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      rx        <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      rx        <= rx_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      busy      <= (state_d != S_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity result of the current frame and its error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= stop_smp & par_bad_q;
    end
  end
`endif

  // Next-state, bit sampling and host-handshake logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    stop_smp    = 1'b0;
    rx_d        = rx;
    valid_d     = valid;
    overrun_d   = overrun;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          // After a break the line must go high again before a new start
          if (sd) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = sd ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d          = '0;
            shift_d[idx_q] = sd;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = AFTER_DATA;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d     = '0;
            par_bad_d = ^{shift_q, sd};
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d    = '0;
            stop_smp = 1'b1;
            armed_d  = sd;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    stop_good   = stop_smp & sd & ~par_bad_q;
    frame_err_d = stop_smp & ~sd;
    consume     = rd_ack & valid;

    if (stop_good) begin
      rx_d    = shift_q;
      valid_d = 1'b1;
      if (valid && !rd_ack) overrun_d = 1'b1;
      else if (consume)     overrun_d = 1'b0;
    end else if (consume) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed plus randomized frames against a frame-level model
// of the receiver's host-visible state (rx, valid, overrun, error pulses).
module tb_uart_rx_os;

  localparam int unsigned DW   = 8;
  localparam int unsigned OS   = 16;
  localparam int unsigned TDIV = 3;

  logic          clk = 1'b0;
  logic          reset, tick, s_data, rd_ack;
  logic [DW-1:0] rx;
  logic          valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int passes = 0;
  int total  = 0;
  int fe_seen = 0;

  // Reference state: what the host should see
  logic [DW-1:0] m_rx;
  logic          m_valid, m_ovr;

  uart_rx_os #(.DATA_BITS(DW), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .s_data    (s_data),
    .rd_ack    (rd_ack),
    .rx        (rx),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Count every cycle frame_err is high
  always @(posedge clk) if (frame_err) fe_seen <= fe_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (TDIV - 1) @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    s_data = b;
    tick_n(5);
    if (stall) repeat ($urandom_range(20, 80)) @(negedge clk);
    tick_n(OS - 5);
  endtask

  task automatic model_reset();
    m_rx = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  // One full frame; the stop sample lands on tick 9 of the stop bit
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_flip,
                            input bit ack_at_stop, input bit stall_ok, input string tag);
    logic good, consumed;
    send_bit(1'b0, 1'b0);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i], stall_ok && ($urandom_range(0, 3) == 0));
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip, 1'b0);
`endif
    s_data = stop_b;
    tick_n(9);
    check({tag, ".valid_pre"}, 32'(valid), 32'(m_valid));
    tick   = 1'b1;
    rd_ack = ack_at_stop;
    @(negedge clk);
    tick   = 1'b0;
    rd_ack = 1'b0;
    good     = stop_b && !par_flip;
    consumed = ack_at_stop && m_valid;
    if (good) begin
      if (m_valid && !consumed) m_ovr = 1'b1;
      else if (consumed)        m_ovr = 1'b0;
      m_rx    = d;
      m_valid = 1'b1;
    end else if (consumed) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check({tag, ".rx"}, 32'(rx), 32'(m_rx));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".ferr"}, 32'(frame_err), 32'(!stop_b));
`ifdef UART_RX_PARITY_EN
    check({tag, ".perr"}, 32'(parity_err), 32'(par_flip));
`endif
    @(negedge clk);
    check({tag, ".ferr_end"}, 32'(frame_err), 32'd0);
    repeat (TDIV - 2) @(negedge clk);
    tick_n(OS - 10);
    s_data = 1'b1;
    tick_n(4);
  endtask

  initial begin
    int fe0;
    logic [DW-1:0] rb;
    tick = 1'b0; s_data = 1'b1; rd_ack = 1'b0; reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst.rx", 32'(rx), 32'd0);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ovr", 32'(overrun), 32'd0);
    check("rst.ferr", 32'(frame_err), 32'd0);

    tick_n(100);
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.valid", 32'(valid), 32'd0);
    check("idle.rx", 32'(rx), 32'd0);
    check("idle.ferr_cnt", 32'(fe_seen), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "a5");
    do_ack("a5_ack");

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "3c");
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, "c3");
    do_ack("c3_ack");

    // Overrun pending, then a good frame arriving together with rd_ack
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, "11");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, "22");
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, "33_same_ack");
    do_ack("33_ack");

    send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0, "66");
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, "55_badstop");
    do_ack("55_ack");

    // Start-bit glitch
    fe0 = fe_seen;
    s_data = 1'b0;
    tick_n(4);
    s_data = 1'b1;
    tick_n(40);
    check("glitch.busy", 32'(busy), 32'd0);
    check("glitch.valid", 32'(valid), 32'(m_valid));
    check("glitch.ferr_cnt", 32'(fe_seen - fe0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, "81");

    // Break: a single frame error, then no restart until the line is high
    fe0 = fe_seen;
    s_data = 1'b0;
    tick_n(OS * 12);
    check("break.ferr_cnt", 32'(fe_seen - fe0), 32'd1);
    check("break.busy", 32'(busy), 32'd0);
    check("break.rx", 32'(rx), 32'(m_rx));
    s_data = 1'b1;
    tick_n(OS);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, "5a");

    // Reset in the middle of a 0xFF frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset  = 1'b1;
    s_data = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midrst.rx", 32'(rx), 32'd0);
    check("midrst.valid", 32'(valid), 32'd0);
    check("midrst.ovr", 32'(overrun), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.ferr", 32'(frame_err), 32'd0);
    tick_n(4);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, "12");
    do_ack("12_ack");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, "07_par_ok");
    do_ack("07_ack");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, "07_par_bad");
    send_frame(8'h3D, 1'b0, 1'b1, 1'b0, 1'b0, "3d_both_bad");
`endif

    // Randomized frames with stalls, occasional bad stop bits and acks
    for (int k = 0; k < 8; k++) begin
      rb = DW'($urandom);
      send_frame(rb, ($urandom_range(0, 4) != 0), 1'b0, 1'b0, 1'b1, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) do_ack($sformatf("rnd%0d_ack", k));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
